cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single ROB-update broadcast bus (reorder tag + value) between the ALU and the SLB.
//  The bus feeds the RS, SLB and ROB wake-up ports.
//  Each producer has a small holding FIFO, so a losing result is never dropped.
//  The bus output is registered: at most one tag is broadcast per cycle; tag 0 means idle.
// PARAMETERS
//  DATA_W      32  result value width
//  TAG_W        4  ROB tag width; tag 0 = "no result" (ZERO_ROB_TAG)
//  FIFO_DEPTH   2  holding entries per producer (power of 2, >=2)
// PORTS
//  clk                 in   1       system clock
//  rst                 in   1       synchronous, active-high reset
//  rdy                 in   1       global enable; state frozen when low
//  in_misbranch        in   1       flush request from ROB
//  in_alu_reorder      in   TAG_W   ALU result tag; nonzero = valid this cycle
//  in_alu_value        in   DATA_W  ALU result value
//  in_slb_reorder      in   TAG_W   SLB result tag; nonzero = valid this cycle
//  in_slb_value        in   DATA_W  SLB result value
//  out_alu_full        out  1       ALU holding FIFO cannot absorb a further loser
//  out_slb_full        out  1       SLB holding FIFO cannot absorb a further loser
//  out_cdb_reorder     out  TAG_W   broadcast tag (registered)
//  out_cdb_value       out  DATA_W  broadcast value (registered)
// BEHAVIOUR
//  Reset: out_cdb_reorder=0, out_cdb_value=0, both FIFOs empty, full flags 0, RR pointer=ALU.
//  rdy=0: no state change; outputs hold.
//  Per-source candidate:
//   - FIFO head if the FIFO is non-empty, else the live input if its tag != 0.
//   - When the FIFO is non-empty, a valid live input is pushed behind the head (age order preserved).
//  Grant:
//   - One winner per cycle; its tag/value are registered onto out_cdb_* at the next edge.
//   - Latency = 1 cycle when uncontended.
//   - Winner FIFO pops if its candidate was the head; a live input that did not win is pushed.
//   - Push and pop on the same FIFO in the same cycle are allowed; count stays unchanged.
//  No candidate: out_cdb_reorder <= 0 (value don't-care, hold last).
//  out_x_full = (count_x >= FIFO_DEPTH-1), combinational from registered count.
//   - The one-entry margin covers producer results already in flight.
//   - Producers stall issue while full is high.
//   - Push into a FIFO that is actually full is illegal (simulation $error); the entry is dropped.
//  Pointers wrap modulo FIFO_DEPTH; count is a separate register, width clog2(FIFO_DEPTH)+1.
//  in_misbranch=1 (with rdy=1):
//   - Both FIFOs are cleared, live inputs that cycle are ignored, and out_cdb_reorder <= 0.
//   - RR pointer is unchanged.
//   - Misbranch takes precedence over all pushes and grants.
//  rst takes precedence over rdy and misbranch; reset mid-stream discards all pending entries.
// CONFIGURATION
//  CDB_ROUND_ROBIN_EN defined:
//   - Round-robin grant between ALU and SLB.
//   - The pointer flips to the non-winner after each grant made while both candidates are valid.
//   - With only one candidate valid, that candidate wins and the pointer is unchanged.
//  CDB_ROUND_ROBIN_EN undefined:
//   - Fixed priority, SLB over ALU; no pointer register is generated.
//   - Mandatory: while SLB keeps the FIFO occupied, ALU full stalls ALU issue.
// TESTING
//  1 Lone ALU: alu tag=3 val=0x11 for 1 cycle -> next cycle cdb tag=3 val=0x11, then tag 0.
//  2 Collision, fixed prio: alu tag=2/0xA and slb tag=5/0xB same cycle
//     -> cdb 5/0xB, then 2/0xA; alu_full pulses 1 for 1 cycle (DEPTH=2).
//  3 Collision, RR_EN: 3 consecutive cycles both valid (alu 1,2,3 / slb 4,5,6)
//     -> order 1,4,2,5,3,6 with no loss; full flags throttle inputs as specified.
//  4 Misbranch: queue slb 7, alu 8, then assert in_misbranch with alu tag 9 live
//     -> cdb tag 0 next cycle; FIFOs empty; tag 9 never broadcast.
//  5 rdy low 3 cycles while alu tag 4 is pending in the FIFO
//     -> cdb output frozen; after rdy high, tag 4 broadcast exactly once.
//  6 Reset mid-stream with both FIFOs holding entries
//     -> next cycle cdb tag 0, full flags 0, no stale tag ever appears.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: shares the registered ROB-update broadcast between ALU and SLB,
// each backed by a holding FIFO. Define CDB_ROUND_ROBIN_EN for round-robin grant (default: SLB priority).
module cdb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_misbranch,
  input  logic [TAG_W-1:0]  in_alu_reorder,
  input  logic [DATA_W-1:0] in_alu_value,
  input  logic [TAG_W-1:0]  in_slb_reorder,
  input  logic [DATA_W-1:0] in_slb_value,
  output logic              out_alu_full,
  output logic              out_slb_full,
  output logic [TAG_W-1:0]  out_cdb_reorder,
  output logic [DATA_W-1:0] out_cdb_value
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned NSRC  = 2;
  localparam bit          SRC_ALU = 1'b0;
  localparam bit          SRC_SLB = 1'b1;
  localparam logic [TAG_W-1:0] ZERO_ROB_TAG = '0;

  // Holding FIFO storage, index 0 = ALU, 1 = SLB
  logic [TAG_W-1:0]  fifo_tag [NSRC][FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_val [NSRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr   [NSRC];
  logic [PTR_W-1:0]  wr_ptr   [NSRC];
  logic [CNT_W-1:0]  count    [NSRC];

  logic [TAG_W-1:0]  live_tag [NSRC];
  logic [DATA_W-1:0] live_val [NSRC];
  logic [TAG_W-1:0]  cand_tag [NSRC];
  logic [DATA_W-1:0] cand_val [NSRC];
  logic [NSRC-1:0]   live_valid;
  logic [NSRC-1:0]   fifo_empty;
  logic [NSRC-1:0]   fifo_full;
  logic [NSRC-1:0]   cand_valid;
  logic [NSRC-1:0]   win;
  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   push_ok;
  logic [NSRC-1:0]   pop;
  logic              grant_valid;
  logic              grant_slb;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_val;

`ifdef CDB_ROUND_ROBIN_EN
  logic rr_ptr;
`endif

  always_comb begin : live_inputs
    live_tag[SRC_ALU] = in_alu_reorder;
    live_val[SRC_ALU] = in_alu_value;
    live_tag[SRC_SLB] = in_slb_reorder;
    live_val[SRC_SLB] = in_slb_value;
  end

  // Per-source candidate: FIFO head has age priority over the live input
  always_comb begin : candidates
    for (int s = 0; s < NSRC; s++) begin
      fifo_empty[s] = (count[s] == '0);
      fifo_full[s]  = (count[s] == CNT_W'(FIFO_DEPTH));
      live_valid[s] = (live_tag[s] != ZERO_ROB_TAG);
      cand_valid[s] = !fifo_empty[s] || live_valid[s];
      cand_tag[s]   = fifo_empty[s] ? live_tag[s] : fifo_tag[s][rd_ptr[s]];
      cand_val[s]   = fifo_empty[s] ? live_val[s] : fifo_val[s][rd_ptr[s]];
    end
  end

  always_comb begin : grant
    grant_valid = |cand_valid;
`ifdef CDB_ROUND_ROBIN_EN
    grant_slb   = (&cand_valid) ? rr_ptr : cand_valid[SRC_SLB];
`else
    grant_slb   = cand_valid[SRC_SLB];
`endif
    win[SRC_ALU] = grant_valid && !grant_slb;
    win[SRC_SLB] = grant_valid && grant_slb;
    win_tag      = grant_slb ? cand_tag[SRC_SLB] : cand_tag[SRC_ALU];
    win_val      = grant_slb ? cand_val[SRC_SLB] : cand_val[SRC_ALU];
    for (int s = 0; s < NSRC; s++) begin
      pop[s]     = win[s] && !fifo_empty[s];
      // A live result is queued unless it went straight onto the bus
      push[s]    = live_valid[s] && !(win[s] && fifo_empty[s]);
      push_ok[s] = push[s] && (!fifo_full[s] || pop[s]);
    end
  end

  always_ff @(posedge clk) begin : control_regs
    if (rst) begin
      out_cdb_reorder <= '0;
      out_cdb_value   <= '0;
      for (int s = 0; s < NSRC; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else if (rdy) begin
      if (in_misbranch) begin
        out_cdb_reorder <= '0;
        for (int s = 0; s < NSRC; s++) begin
          rd_ptr[s] <= '0;
          wr_ptr[s] <= '0;
          count[s]  <= '0;
        end
      end else begin
        out_cdb_reorder <= grant_valid ? win_tag : ZERO_ROB_TAG;
        if (grant_valid) begin
          out_cdb_value <= win_val;
        end
        for (int s = 0; s < NSRC; s++) begin
          if (push_ok[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
          if (pop[s])     rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
          if (push_ok[s] && !pop[s]) begin
            count[s] <= count[s] + CNT_W'(1);
          end else if (!push_ok[s] && pop[s]) begin
            count[s] <= count[s] - CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin : fifo_storage
    if (!rst && rdy && !in_misbranch) begin
      for (int s = 0; s < NSRC; s++) begin
        if (push_ok[s]) begin
          fifo_tag[s][wr_ptr[s]] <= live_tag[s];
          fifo_val[s][wr_ptr[s]] <= live_val[s];
        end
      end
    end
  end

`ifdef CDB_ROUND_ROBIN_EN
  // Pointer names the source favoured on the next contested cycle
  always_ff @(posedge clk) begin : rr_reg
    if (rst) begin
      rr_ptr <= SRC_ALU;
    end else if (rdy && !in_misbranch && (&cand_valid)) begin
      rr_ptr <= !grant_slb;
    end
  end
`endif

  always_ff @(posedge clk) begin : overflow_check
    if (!rst && rdy && !in_misbranch) begin
      assert ((push & ~push_ok) == '0)
        else $error("cdb_arbiter: push into full holding FIFO, entry dropped");
    end
  end

  // One-entry margin covers a producer result already in flight
  assign out_alu_full = (count[SRC_ALU] >= CNT_W'(FIFO_DEPTH - 1));
  assign out_slb_full = (count[SRC_SLB] >= CNT_W'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for single-cycle behaviour plus a throttled
// back-to-back collision sequence. Expectations follow CDB_ROUND_ROBIN_EN when defined.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, in_misbranch;
  logic [3:0]  in_alu_reorder, in_slb_reorder;
  logic [31:0] in_alu_value, in_slb_value;
  logic        out_alu_full, out_slb_full;
  logic [3:0]  out_cdb_reorder;
  logic [31:0] out_cdb_value;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.DATA_W(32), .TAG_W(4), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .in_misbranch    (in_misbranch),
    .in_alu_reorder  (in_alu_reorder),
    .in_alu_value    (in_alu_value),
    .in_slb_reorder  (in_slb_reorder),
    .in_slb_value    (in_slb_value),
    .out_alu_full    (out_alu_full),
    .out_slb_full    (out_slb_full),
    .out_cdb_reorder (out_cdb_reorder),
    .out_cdb_value   (out_cdb_value)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        misb;
    logic [3:0]  alu_tag;
    logic [31:0] alu_val;
    logic [3:0]  slb_tag;
    logic [31:0] slb_val;
    logic [3:0]  exp_tag;
    logic [31:0] exp_val;
    logic        chk_val;
    logic        exp_alu_full;
    logic        exp_slb_full;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int r, input int y, input int m,
                              input int at, input int av, input int st, input int sv,
                              input int et, input int ev, input int cv,
                              input int eaf, input int esf);
    vec_t v;
    v.rst = 1'(r);            v.rdy = 1'(y);            v.misb = 1'(m);
    v.alu_tag = 4'(at);       v.alu_val = 32'(av);
    v.slb_tag = 4'(st);       v.slb_val = 32'(sv);
    v.exp_tag = 4'(et);       v.exp_val = 32'(ev);      v.chk_val = 1'(cv);
    v.exp_alu_full = 1'(eaf); v.exp_slb_full = 1'(esf);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;            rdy = v.rdy;            in_misbranch = v.misb;
    in_alu_reorder = v.alu_tag; in_alu_value = v.alu_val;
    in_slb_reorder = v.slb_tag; in_slb_value = v.slb_val;
  endtask

  int alu_q[3] = '{1, 2, 3};
  int slb_q[3] = '{4, 5, 6};
  int exp_order[6];
  int got_tag[$];
  int got_val[$];
  int alu_i, slb_i;

  initial begin
    // args: rst rdy misb | alu tag/val | slb tag/val | exp tag/val chk_val | alu_full slb_full
    add(1,1,0, 0,0,     0,0,      0,0,1,     0,0);
    add(0,1,0, 3,'h11,  0,0,      3,'h11,1,  0,0);
    add(0,1,0, 0,0,     0,0,      0,0,0,     0,0);
    add(1,1,0, 0,0,     0,0,      0,0,1,     0,0);
`ifdef CDB_ROUND_ROBIN_EN
    add(0,1,0, 2,'hA,   5,'hB,    2,'hA,1,   0,1);
    add(0,1,0, 0,0,     0,0,      5,'hB,1,   0,0);
`else
    add(0,1,0, 2,'hA,   5,'hB,    5,'hB,1,   1,0);
    add(0,1,0, 0,0,     0,0,      2,'hA,1,   0,0);
`endif
    add(0,1,0, 0,0,     0,0,      0,0,0,     0,0);
    // misbranch discards queued alu 8 and live alu 9
    add(0,1,0, 8,'h80,  7,'h70,   7,'h70,1,  1,0);
    add(0,1,1, 9,'h90,  0,0,      0,0,0,     0,0);
    add(0,1,0, 0,0,     0,0,      0,0,0,     0,0);
    add(0,1,0, 0,0,     0,0,      0,0,0,     0,0);
    // rdy low freezes everything while alu 4 waits in its FIFO
`ifdef CDB_ROUND_ROBIN_EN
    add(0,1,0, 14,'hE0, 13,'hD0,  14,'hE0,1, 0,1);
    add(0,1,0, 4,'h40,  0,0,      13,'hD0,1, 1,0);
`else
    add(0,1,0, 4,'h40,  13,'hD0,  13,'hD0,1, 1,0);
`endif
    for (int k = 0; k < 3; k++) add(0,0,0, 15,'hF0, 14,'hE1, 13,'hD0,1, 1,0);
    add(0,1,0, 0,0,     0,0,      4,'h40,1,  0,0);
    add(0,1,0, 0,0,     0,0,      0,0,0,     0,0);
    // reset with entries pending, rdy low and live inputs present
`ifdef CDB_ROUND_ROBIN_EN
    add(0,1,0, 6,'h60,  10,'hA0,  6,'h60,1,  0,1);
`else
    add(0,1,0, 6,'h60,  10,'hA0,  10,'hA0,1, 1,0);
`endif
    add(1,0,0, 11,'hB0, 12,'hC0,  0,0,1,     0,0);
    add(0,1,0, 0,0,     0,0,      0,0,0,     0,0);
    add(0,1,0, 0,0,     0,0,      0,0,0,     0,0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("row%0d tag", i), 32'(out_cdb_reorder), 32'(vecs[i].exp_tag));
      if (vecs[i].chk_val)
        check($sformatf("row%0d value", i), out_cdb_value, vecs[i].exp_val);
      check($sformatf("row%0d alu_full", i), 32'(out_alu_full), 32'(vecs[i].exp_alu_full));
      check($sformatf("row%0d slb_full", i), 32'(out_slb_full), 32'(vecs[i].exp_slb_full));
    end

    // Back-to-back collisions, producers honouring the full flags
`ifdef CDB_ROUND_ROBIN_EN
    exp_order = '{1, 4, 2, 5, 3, 6};
`else
    exp_order = '{4, 5, 6, 1, 2, 3};
`endif
    rst = 1'b1; rdy = 1'b1; in_misbranch = 1'b0;
    in_alu_reorder = '0; in_slb_reorder = '0; in_alu_value = '0; in_slb_value = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    alu_i = 0;
    slb_i = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (alu_i < 3 && !out_alu_full) begin
        in_alu_reorder = 4'(alu_q[alu_i]);
        in_alu_value   = 32'(alu_q[alu_i] + 'h100);
        alu_i++;
      end else begin
        in_alu_reorder = '0;
      end
      if (slb_i < 3 && !out_slb_full) begin
        in_slb_reorder = 4'(slb_q[slb_i]);
        in_slb_value   = 32'(slb_q[slb_i] + 'h100);
        slb_i++;
      end else begin
        in_slb_reorder = '0;
      end
      @(posedge clk);
      #1;
      if (out_cdb_reorder != 4'd0) begin
        got_tag.push_back(int'(out_cdb_reorder));
        got_val.push_back(int'(out_cdb_value));
      end
    end
    check("burst count", 32'(got_tag.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_tag.size()) begin
        check($sformatf("burst tag%0d", i), 32'(got_tag[i]), 32'(exp_order[i]));
        check($sformatf("burst value%0d", i), 32'(got_val[i]), 32'(exp_order[i] + 'h100));
      end else begin
        check($sformatf("burst tag%0d missing", i), 32'hFFFF_FFFF, 32'(exp_order[i]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
